// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// transmit FIFO status bit positions and default burst length.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  localparam int EMPTY_BIT     = 0;
  localparam int FULL_BIT      = 1;
  localparam int MAX_BURST_DEF = 16;
  localparam int GRANT_W       = 2;
  localparam int BEAT_CNT_W    = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last_grant+1 upward
// (wrapping) and reports the first requester with valid set.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [1:0]         i_last_grant,
  output logic [1:0]         o_winner,
  output logic               o_any_valid
);

  // Walk the candidates in priority order; the first valid one wins.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any_valid && i_valid[j] &&
            (j == ((int'(i_last_grant) + k) % NUM_REQ))) begin
          o_winner    = 2'(j);
          o_any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting NUM_REQ byte sources share one UART
// transmit FIFO write port. A grant is held until the holder's last
// byte or until MAX_BURST beats, with one idle cycle between grants.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fwdata,
  output logic                          fwrite,
  input  logic [3:0]                    fwstatus,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
);

  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [GRANT_W-1:0]      r_grant_id;
  logic [GRANT_W-1:0]      r_last_grant;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;

  logic [GRANT_W-1:0]      w_winner;
  logic                    w_any_valid;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_full;
  logic                    w_hold;
  logic                    w_accept;
  logic                    w_release;
  logic                    w_grant;
  logic                    w_unused_status;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  // Only the full flag throttles writes; empty and the upper bits are informational.
  assign w_unused_status = ^{fwstatus[3:2], fwstatus[EMPTY_BIT]};
  assign w_full          = fwstatus[FULL_BIT];

  // Route the current holder's valid/last/data onto the shared path.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GRANT_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset wins immediately: a hold being torn down must not write the FIFO.
  assign w_hold    = (r_state == ST_XFER) && !reset;
  assign w_accept  = w_hold && !w_full && w_sel_valid;
  assign w_release = w_accept && (w_sel_last || (r_beat_cnt == BURST_LAST));
  assign w_grant   = (r_state == ST_IDLE) && enable && w_any_valid;

  // Ready goes only to the holder, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (w_hold && !w_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant_id == GRANT_W'(i)) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  assign fwrite   = w_accept;
  assign fwdata   = w_hold ? w_sel_data : '0;
  assign busy     = (r_state == ST_XFER);
  assign grant_id = r_grant_id;

  // Next-state logic: grant out of IDLE, release on last or burst limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)   w_state_nxt = ST_XFER;
      ST_XFER: if (w_release) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant bookkeeping: latch winner, count beats, remember who last held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_id   <= '0;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_winner;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) begin
        r_last_grant <= r_grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a fixed vector table, directed multi-cycle
// message scenarios and randomized traffic against a behavioural model.
// Two instances are used: dut_a with MAX_BURST=16, dut_b with MAX_BURST=4.
module tb_uart_tx_arbiter;

  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic        en_s   [2];
  logic [2:0]  vld_s  [2];
  logic [2:0]  lst_s  [2];
  logic [23:0] dat_s  [2];
  logic [3:0]  fws_s  [2];
  logic [2:0]  rdy_s  [2];
  logic [7:0]  fwd_s  [2];
  logic        fw_s   [2];
  logic [1:0]  gid_s  [2];
  logic        busy_s [2];

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(16)) dut_a (
    .clk(clk), .reset(rst_s[0]), .enable(en_s[0]), .req_valid(vld_s[0]),
    .req_data(dat_s[0]), .req_last(lst_s[0]), .req_ready(rdy_s[0]),
    .fwdata(fwd_s[0]), .fwrite(fw_s[0]), .fwstatus(fws_s[0]),
    .grant_id(gid_s[0]), .busy(busy_s[0]));

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) dut_b (
    .clk(clk), .reset(rst_s[1]), .enable(en_s[1]), .req_valid(vld_s[1]),
    .req_data(dat_s[1]), .req_last(lst_s[1]), .req_ready(rdy_s[1]),
    .fwdata(fwd_s[1]), .fwrite(fw_s[1]), .fwstatus(fws_s[1]),
    .grant_id(gid_s[1]), .busy(busy_s[1]));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic r, input logic e, input logic [2:0] v,
                       input logic [2:0] l, input logic [23:0] d, input logic f);
    rst_s[s] = r;
    en_s[s]  = e;
    vld_s[s] = v;
    lst_s[s] = l;
    dat_s[s] = d;
    fws_s[s] = {2'($urandom), f, 1'($urandom)};
  endtask

  // ---------------- behavioural reference model ----------------
  // hold = index of the requester owning the FIFO, -1 when nobody does.
  int m_hold [2];
  int m_gid  [2];
  int m_lastg[2];
  int m_cnt  [2];
  int mb     [2];

  function automatic void m_predict(input int s, input logic r, input logic [23:0] d,
                                    input logic [2:0] v, input logic f,
                                    output logic busy, output logic [1:0] gid,
                                    output logic [2:0] rdy, output logic fw,
                                    output logic [7:0] fd);
    busy = (m_hold[s] >= 0);
    gid  = 2'(m_gid[s]);
    rdy  = 3'b000;
    fw   = 1'b0;
    fd   = 8'h00;
    if (!r && m_hold[s] >= 0) begin
      fd = 8'(d >> (m_hold[s] * 8));
      if (!f) rdy = 3'b001 << m_hold[s];
      fw = |(rdy & v);
    end
  endfunction

  function automatic void m_update(input int s, input logic r, input logic e,
                                   input logic [2:0] v, input logic [2:0] l, input logic fw);
    if (r) begin
      m_hold[s] = -1; m_gid[s] = 0; m_lastg[s] = NR - 1; m_cnt[s] = 0;
    end else if (m_hold[s] < 0) begin
      if (e) begin
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_lastg[s] + k) % NR;
          if (m_hold[s] < 0 && ((v >> i) & 3'b001) != 3'b000) begin
            m_hold[s] = i; m_gid[s] = i; m_cnt[s] = 0;
          end
        end
      end
    end else if (fw) begin
      m_cnt[s]++;
      if (((l >> m_hold[s]) & 3'b001) != 3'b000 || m_cnt[s] == mb[s]) begin
        m_lastg[s] = m_hold[s];
        m_hold[s]  = -1;
      end
    end
  endfunction

  // ---------------- message sources and write log ----------------
  logic [7:0] mem_d[3][64];
  logic       mem_l[3][64];
  int         head[3], tail[3], start[3];
  logic       en_sch[64];
  int         en_n;
  logic       fl_sch[64];
  int         fl_n;
  logic [7:0] log_d[512];
  int         log_g[512], log_c[512];
  int         log_n;

  task automatic clear_stim();
    for (int i = 0; i < 3; i++) begin
      head[i] = 0; tail[i] = 0; start[i] = 0;
    end
    en_n = 0; fl_n = 0; log_n = 0;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem_d[i][tail[i]] = d;
    mem_l[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic do_reset(input int s);
    drive(s, 1'b1, 1'b0, 3'b000, 3'b000, 24'h0, 1'b0);
    tick();
    tick();
    m_update(s, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
  endtask

  task automatic run(input string tag, input int s, input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      logic r, e, f, ebusy, efw;
      logic [2:0] v, l, erdy;
      logic [23:0] d;
      logic [1:0] egid;
      logic [7:0] efd;
      r = rnd ? ($urandom_range(0, 99) == 0) : 1'b0;
      e = rnd ? ($urandom_range(0, 9) != 0) : ((c < en_n) ? en_sch[c] : 1'b1);
      f = rnd ? ($urandom_range(0, 4) == 0) : ((c < fl_n) ? fl_sch[c] : 1'b0);
      d = 24'($urandom);
      l = 3'($urandom);
      v = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (head[i] < tail[i] && c >= start[i]) begin
          v[i] = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
          d[i*8 +: 8] = mem_d[i][head[i]];
          l[i] = mem_l[i][head[i]];
        end
      end
      drive(s, r, e, v, l, d, f);
      #1;
      m_predict(s, r, d, v, f, ebusy, egid, erdy, efw, efd);
      chk($sformatf("%s c%0d busy", tag, c),   32'(busy_s[s]), 32'(ebusy));
      chk($sformatf("%s c%0d gid", tag, c),    32'(gid_s[s]),  32'(egid));
      chk($sformatf("%s c%0d ready", tag, c),  32'(rdy_s[s]),  32'(erdy));
      chk($sformatf("%s c%0d fwrite", tag, c), 32'(fw_s[s]),   32'(efw));
      chk($sformatf("%s c%0d fwdata", tag, c), 32'(fwd_s[s]),  32'(efd));
      if (fw_s[s] === 1'b1 && log_n < 512) begin
        log_d[log_n] = fwd_s[s];
        log_g[log_n] = int'(gid_s[s]);
        log_c[log_n] = c;
        log_n++;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && rdy_s[s][i] === 1'b1) head[i]++;
      end
      m_update(s, r, e, v, l, efw);
      tick();
    end
  endtask

  task automatic exp_log(input string tag, input int k, input int g, input logic [7:0] d);
    logic [31:0] act;
    act = (k < log_n) ? {22'h0, 2'(log_g[k]), log_d[k]} : 32'hFFFF_FFFF;
    chk($sformatf("%s log[%0d] {gid,byte}", tag, k), act, {22'h0, 2'(g), d});
  endtask

  task automatic check_order(input string tag);
    int idx[3];
    for (int i = 0; i < 3; i++) idx[i] = 0;
    for (int k = 0; k < log_n; k++) begin
      int g;
      g = log_g[k];
      if (g < 3 && idx[g] < 64) begin
        chk($sformatf("%s order req%0d #%0d", tag, g, idx[g]), 32'(log_d[k]), 32'(mem_d[g][idx[g]]));
        idx[g]++;
      end else begin
        chk($sformatf("%s bad gid in log", tag), 32'(g), 32'(0));
      end
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s count req%0d", tag, i), 32'(idx[i]), 32'(head[i]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] vld;
    logic [2:0] lst;
    logic       full;
    logic       e_busy;
    logic [1:0] e_gid;
    logic       e_fw;
    logic [2:0] e_rdy;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[32];
  int   nt = 0;

  task automatic addv(input logic r, input logic e, input logic f, input logic b,
                      input logic [1:0] g, input logic w, input logic [2:0] rd,
                      input logic [7:0] dt);
    tbl[nt].rst = r;  tbl[nt].en = e;  tbl[nt].vld = 3'b111; tbl[nt].lst = 3'b111;
    tbl[nt].full = f; tbl[nt].e_busy = b; tbl[nt].e_gid = g; tbl[nt].e_fw = w;
    tbl[nt].e_rdy = rd; tbl[nt].e_dat = dt;
    nt++;
  endtask

  initial begin
    mb[0] = 16;
    mb[1] = 4;
    for (int s = 0; s < 2; s++) drive(s, 1'b1, 1'b0, 3'b000, 3'b000, 24'h0, 1'b0);

    // All three requesters valid with single-byte messages:
    // rst en full | busy gid fwrite ready fwdata
    addv(0, 1, 0, 0, 2'd0, 0, 3'b000, 8'h00);  // reset state, grants 0
    addv(0, 1, 0, 1, 2'd0, 1, 3'b001, 8'hA0);
    addv(0, 1, 0, 0, 2'd0, 0, 3'b000, 8'h00);  // idle gap, grants 1
    addv(0, 1, 0, 1, 2'd1, 1, 3'b010, 8'hB1);
    addv(0, 1, 0, 0, 2'd1, 0, 3'b000, 8'h00);
    addv(0, 1, 0, 1, 2'd2, 1, 3'b100, 8'hC2);
    addv(0, 1, 0, 0, 2'd2, 0, 3'b000, 8'h00);
    addv(0, 1, 0, 1, 2'd0, 1, 3'b001, 8'hA0);  // wrapped back to 0
    addv(0, 1, 0, 0, 2'd0, 0, 3'b000, 8'h00);  // grants 1
    addv(1, 1, 0, 1, 2'd1, 0, 3'b000, 8'h00);  // reset during hold: no write
    addv(0, 1, 0, 0, 2'd0, 0, 3'b000, 8'h00);  // busy=0, gid=0, grants 0 again
    addv(0, 1, 0, 1, 2'd0, 1, 3'b001, 8'hA0);
    addv(0, 1, 0, 0, 2'd0, 0, 3'b000, 8'h00);  // grants 1
    addv(0, 1, 1, 1, 2'd1, 0, 3'b000, 8'hB1);  // FIFO full: stall
    addv(0, 1, 0, 1, 2'd1, 1, 3'b010, 8'hB1);
    addv(0, 0, 0, 0, 2'd1, 0, 3'b000, 8'h00);  // enable low: no grant
    addv(0, 0, 0, 0, 2'd1, 0, 3'b000, 8'h00);
    addv(0, 1, 0, 0, 2'd1, 0, 3'b000, 8'h00);  // grants 2
    addv(0, 1, 0, 1, 2'd2, 1, 3'b100, 8'hC2);

    tick();
    tick();
    for (int t = 0; t < nt; t++) begin
      for (int s = 0; s < 2; s++)
        drive(s, tbl[t].rst, tbl[t].en, tbl[t].vld, tbl[t].lst, 24'hC2B1A0, tbl[t].full);
      #1;
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("tbl%0d dut%0d busy", t, s),   32'(busy_s[s]), 32'(tbl[t].e_busy));
        chk($sformatf("tbl%0d dut%0d gid", t, s),    32'(gid_s[s]),  32'(tbl[t].e_gid));
        chk($sformatf("tbl%0d dut%0d fwrite", t, s), 32'(fw_s[s]),   32'(tbl[t].e_fw));
        chk($sformatf("tbl%0d dut%0d ready", t, s),  32'(rdy_s[s]),  32'(tbl[t].e_rdy));
        chk($sformatf("tbl%0d dut%0d fwdata", t, s), 32'(fwd_s[s]),  32'(tbl[t].e_dat));
      end
      tick();
    end

    // Requester 1 holds for a 5-byte message while requester 0 waits.
    clear_stim();
    for (int k = 0; k < 5; k++) push(1, 8'(8'h41 + k), k == 4);
    push(0, 8'h10, 1'b1);
    start[0] = 1;
    do_reset(0);
    run("msg5", 0, 10, 1'b0);
    chk("msg5 writes", 32'(log_n), 32'd6);
    for (int k = 0; k < 5; k++) exp_log("msg5", k, 1, 8'(8'h41 + k));
    exp_log("msg5", 5, 0, 8'h10);

    // Burst limit 4: requester 2 streams 10 bytes, requester 0 slips in.
    clear_stim();
    for (int k = 0; k < 10; k++) push(2, 8'(8'h50 + k), k == 9);
    push(0, 8'h01, 1'b1);
    start[0] = 1;
    do_reset(1);
    run("burst", 1, 18, 1'b0);
    chk("burst writes", 32'(log_n), 32'd11);
    for (int k = 0; k < 4; k++) exp_log("burst", k, 2, 8'(8'h50 + k));
    exp_log("burst", 4, 0, 8'h01);
    for (int k = 4; k < 10; k++) exp_log("burst", k + 1, 2, 8'(8'h50 + k));

    // FIFO full for 3 cycles in the middle of a 4-byte message.
    clear_stim();
    for (int k = 0; k < 4; k++) push(0, 8'(8'h60 + k), k == 3);
    for (int c = 0; c < 6; c++) fl_sch[c] = (c >= 3);
    fl_n = 6;
    do_reset(0);
    run("full", 0, 10, 1'b0);
    chk("full writes", 32'(log_n), 32'd4);
    for (int k = 0; k < 4; k++) exp_log("full", k, 0, 8'(8'h60 + k));
    chk("full resume cycle", 32'(log_c[2]), 32'd6);

    // Enable dropped during byte 2: message completes, no new grant until enable returns.
    clear_stim();
    for (int k = 0; k < 4; k++) push(0, 8'(8'h70 + k), k == 3);
    push(1, 8'h80, 1'b0);
    push(1, 8'h81, 1'b1);
    for (int c = 0; c < 10; c++) en_sch[c] = (c < 2);
    en_n = 10;
    do_reset(0);
    run("enable", 0, 15, 1'b0);
    chk("enable writes", 32'(log_n), 32'd6);
    for (int k = 0; k < 4; k++) exp_log("enable", k, 0, 8'(8'h70 + k));
    exp_log("enable", 4, 1, 8'h80);
    exp_log("enable", 5, 1, 8'h81);
    chk("enable regrant cycle", 32'(log_c[4]), 32'd11);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int rnd = 0; rnd < 2; rnd++) begin
        clear_stim();
        for (int i = 0; i < 3; i++) begin
          while (tail[i] < 40) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) push(i, 8'($urandom), j == len - 1);
          end
        end
        do_reset(s);
        run($sformatf("rand%0d.%0d", s, rnd), s, 400, 1'b1);
        check_order($sformatf("rand%0d.%0d", s, rnd));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
